// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//   Iterative RV32M multiply/divide unit placed between the register file
//   read ports (RD1/RD2) and the write port (WD3/A3/WE3). One operation at
//   a time: XLEN shift-add (multiply) or restoring shift-subtract (divide)
//   steps on operand magnitudes, then a single fix-up cycle that applies
//   the sign and selects the returned word.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : request, accepted only when idle
//   funct3   : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_val  : operand A (dividend / multiplicand)
//   rs2_val  : operand B (divisor / multiplier)
//   rd_in    : destination register index
//   busy     : high while an operation is in flight (core stalls on it)
//   done     : one-cycle pulse, result valid in that cycle
//   result   : operation result, held until the next done
//   rd_out   : destination index of the completed operation (A3)
//   we_out   : register file write enable (WE3), done with rd_out != 0
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [2:0]      op;
    logic [4:0]      rd_lat;
    logic [CW-1:0]   cnt;
    logic            fast;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] q;
    logic            neg_res;
    logic            neg_rem;

    logic            accept;
    logic            last_step;
    logic            signed_a;
    logic            signed_b;
    logic            sign_a;
    logic            sign_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   res_sel;

    assign accept    = (state == IDLE) && start;
    assign last_step = (cnt == CW'(XLEN - 1));

    // Operand decode at acceptance. MUL is treated as signed x signed; its
    // low word is identical either way. Divide-by-zero and the single
    // signed-overflow case are detected here and bypass the iteration.
    always_comb begin
        signed_a = !((funct3 == 3'b011) || (funct3 == 3'b101) || (funct3 == 3'b111));
        signed_b = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_a   = signed_a && rs1_val[XLEN-1];
        sign_b   = signed_b && rs2_val[XLEN-1];
        mag_a    = sign_a ? ('0 - rs1_val) : rs1_val;
        mag_b    = sign_b ? ('0 - rs2_val) : rs2_val;
        div_zero = funct3[2] && (rs2_val == '0);
        div_ovf  = funct3[2] && !funct3[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
    end

    // One iteration step. Multiply keeps {acc,q} as the running product
    // with the multiplier shifting out of q. Divide keeps the partial
    // remainder in acc and shifts quotient bits into q as the dividend
    // shifts out. Because acc < divisor holds throughout, the difference
    // always fits in XLEN+1 bits and its top bit is the borrow.
    always_comb begin
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, mcand} : '0);
        div_shift = {acc, q[XLEN-1]};
        div_diff  = div_shift - {1'b0, divisor};
    end

    // Sign correction and word selection used in the fix-up cycle. The
    // fast path preloads q/acc with the final quotient/remainder and
    // clears both sign flags, so it flows through the same selection.
    always_comb begin
        prod     = {acc, q};
        prod_fix = neg_res ? ('0 - prod) : prod;
        quo_fix  = neg_res ? ('0 - q) : q;
        rem_fix  = neg_rem ? ('0 - acc) : acc;
        case (op)
            3'b000:                 res_sel = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_sel = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_sel = quo_fix;
            default:                res_sel = rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A fast-path operation still spends one cycle in
    // CALC (without stepping) so its done lands two edges after
    // acceptance, with the result chosen in FIX like every other op.
    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (fast || last_step) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, iterate in CALC, publish the
    // result in FIX. done is a registered pulse for the cycle after FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op      <= 3'b000;
            rd_lat  <= 5'd0;
            cnt     <= '0;
            fast    <= 1'b0;
            mcand   <= '0;
            divisor <= '0;
            acc     <= '0;
            q       <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
            rd_out  <= 5'd0;
            done    <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (accept) begin
                op      <= funct3;
                rd_lat  <= rd_in;
                cnt     <= '0;
                fast    <= div_zero || div_ovf;
                mcand   <= mag_a;
                divisor <= mag_b;
                if (div_zero) begin
                    q       <= '1;
                    acc     <= rs1_val;
                    neg_res <= 1'b0;
                    neg_rem <= 1'b0;
                end else if (div_ovf) begin
                    q       <= MIN_NEG;
                    acc     <= '0;
                    neg_res <= 1'b0;
                    neg_rem <= 1'b0;
                end else begin
                    acc     <= '0;
                    q       <= funct3[2] ? mag_a : mag_b;
                    neg_res <= sign_a ^ sign_b;
                    neg_rem <= sign_a;
                end
            end else if (state == CALC && !fast) begin
                cnt <= cnt + 1'b1;
                if (op[2]) begin
                    if (!div_diff[XLEN]) begin
                        acc <= div_diff[XLEN-1:0];
                        q   <= {q[XLEN-2:0], 1'b1};
                    end else begin
                        acc <= div_shift[XLEN-1:0];
                        q   <= {q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    {acc, q} <= {mul_sum, q[XLEN-1:1]};
                end
            end else if (state == FIX) begin
                result <= res_sel;
                rd_out <= rd_lat;
            end
        end
    end

    assign we_out = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq
//   Self-checking bench for muldiv_seq (XLEN = 32). Expected results are
//   pushed to a scoreboard queue when an operation is issued and popped
//   when done pulses. Constants come from the RV32M definition; the random
//   section uses a 64-bit reference model written with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    int checks;
    int errors;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    exp_t sb_q[$];

    muldiv_seq #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out),
        .we_out  (we_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model for one RV32M operation.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ub_s;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        int                 ia;
        int                 ib;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        ub_s = ub;
        ia   = a;
        ib   = b;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub_s; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Drive one request so that the next rising edge is the acceptance
    // edge E0. With sync = 1 it first moves to a falling edge; with
    // sync = 0 it drives in the current cycle (used in the done cycle).
    task automatic issue(input bit sync, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        if (sync) @(negedge clk);
        start   = 1'b1;
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait on falling edges for done. edge_idx is the index k of the
    // rising edge Ek after which done was seen (-1 on timeout); busy_cnt
    // counts falling-edge samples with busy high before done.
    task automatic wait_done(input int start_edge, output int edge_idx, output int busy_cnt);
        int n;
        n        = start_edge;
        edge_idx = -1;
        busy_cnt = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (done) begin
                edge_idx = n - 1;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        rd_in  = 5'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done); end
        checks++;
        if (we_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b exp 0", we_out); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result got %h exp 0", result); end
    endtask

    task automatic test_mul();
        int   e;
        int   bc;
        exp_t x;
        issue(1'b1, 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5);
        sb_q.push_back('{res: 32'hFFFFFFEB, rd: 5'd5, we: 1'b1});
        wait_done(0, e, bc);
        checks++;
        if (e !== 33) begin errors++; $display("[TB] FAIL mul_latency got %0d exp 33", e); end
        checks++;
        if (bc !== 33) begin errors++; $display("[TB] FAIL mul_busy_cycles got %0d exp 33", bc); end
        x = sb_q.pop_front();
        checks++;
        if (result !== x.res) begin errors++; $display("[TB] FAIL mul_result got %h exp %h", result, x.res); end
        checks++;
        if (rd_out !== x.rd || we_out !== x.we)
            begin errors++; $display("[TB] FAIL mul_rd_we got %0d/%b exp %0d/%b", rd_out, we_out, x.rd, x.we); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== x.res)
            begin errors++; $display("[TB] FAIL mul_hold got done %b res %h exp 0 %h", done, result, x.res); end
    endtask

    task automatic test_mulh();
        vec_t v[3];
        int   e;
        int   bc;
        exp_t x;
        v[0] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
        v[1] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        v[2] = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, v[i].f, v[i].a, v[i].b, 5'(i + 10));
            sb_q.push_back('{res: v[i].res, rd: 5'(i + 10), we: 1'b1});
            wait_done(0, e, bc);
            x = sb_q.pop_front();
            checks++;
            if (e !== 33 || result !== x.res)
                begin errors++; $display("[TB] FAIL mulh_%0d got %h at E%0d exp %h at E33", i, result, e, x.res); end
        end
    endtask

    task automatic test_div();
        vec_t v[4];
        int   e;
        int   bc;
        exp_t x;
        v[0] = '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD};
        v[1] = '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF};
        v[2] = '{3'b101, 32'd100, 32'd7, 32'd14};
        v[3] = '{3'b111, 32'd100, 32'd7, 32'd2};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, v[i].f, v[i].a, v[i].b, 5'(i + 1));
            sb_q.push_back('{res: v[i].res, rd: 5'(i + 1), we: 1'b1});
            wait_done(0, e, bc);
            x = sb_q.pop_front();
            checks++;
            if (e !== 33 || result !== x.res || rd_out !== x.rd)
                begin errors++; $display("[TB] FAIL div_%0d got %h rd %0d at E%0d exp %h rd %0d at E33", i, result, rd_out, e, x.res, x.rd); end
        end
    endtask

    task automatic test_div_special();
        vec_t v[4];
        int   e;
        int   bc;
        exp_t x;
        v[0] = '{3'b101, 32'h00001234, 32'd0, 32'hFFFFFFFF};
        v[1] = '{3'b111, 32'h00001234, 32'd0, 32'h00001234};
        v[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        v[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, v[i].f, v[i].a, v[i].b, 5'(i + 20));
            sb_q.push_back('{res: v[i].res, rd: 5'(i + 20), we: 1'b1});
            wait_done(0, e, bc);
            x = sb_q.pop_front();
            checks++;
            if (e !== 2 || result !== x.res)
                begin errors++; $display("[TB] FAIL divspec_%0d got %h at E%0d exp %h at E2", i, result, e, x.res); end
        end
    endtask

    task automatic test_ignore_start();
        int   e;
        int   bc;
        int   extra;
        exp_t x;
        issue(1'b1, 3'b101, 32'd100, 32'd7, 5'd3);
        sb_q.push_back('{res: 32'd14, rd: 5'd3, we: 1'b1});
        repeat (10) @(negedge clk);
        issue(1'b0, 3'b000, 32'd5, 32'd6, 5'd4);
        wait_done(10, e, bc);
        x = sb_q.pop_front();
        checks++;
        if (e !== 33 || result !== x.res || rd_out !== x.rd)
            begin errors++; $display("[TB] FAIL ignore_start got %h rd %0d at E%0d exp %h rd %0d at E33", result, rd_out, e, x.res, x.rd); end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("[TB] FAIL ignore_no_queue got %0d extra done exp 0", extra); end
    endtask

    task automatic test_reset_abort();
        int seen;
        issue(1'b1, 3'b101, 32'd1000, 32'd3, 5'd9);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("[TB] FAIL abort_busy got busy %b done %b exp 0 0", busy, done); end
        checks++;
        if (result !== 32'd0 || rd_out !== 5'd0 || we_out !== 1'b0)
            begin errors++; $display("[TB] FAIL abort_clear got %h rd %0d we %b exp 0", result, rd_out, we_out); end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d active cycles exp 0", seen); end
    endtask

    task automatic test_back_to_back();
        int   e;
        int   bc;
        exp_t x;
        issue(1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
        sb_q.push_back('{res: 32'hFFFFFFFE, rd: 5'd7, we: 1'b1});
        wait_done(0, e, bc);
        x = sb_q.pop_front();
        checks++;
        if (e !== 33 || result !== x.res)
            begin errors++; $display("[TB] FAIL b2b_first got %h at E%0d exp %h at E33", result, e, x.res); end
        issue(1'b0, 3'b101, 32'd100, 32'd7, 5'd8);
        sb_q.push_back('{res: 32'd14, rd: 5'd8, we: 1'b1});
        wait_done(0, e, bc);
        x = sb_q.pop_front();
        checks++;
        if (e !== 33 || result !== x.res || rd_out !== x.rd)
            begin errors++; $display("[TB] FAIL b2b_second got %h rd %0d at E%0d exp %h rd %0d at E33", result, rd_out, e, x.res, x.rd); end
    endtask

    task automatic test_rd_zero();
        int   e;
        int   bc;
        exp_t x;
        issue(1'b1, 3'b111, 32'd100, 32'd7, 5'd0);
        sb_q.push_back('{res: 32'd2, rd: 5'd0, we: 1'b0});
        wait_done(0, e, bc);
        x = sb_q.pop_front();
        checks++;
        if (e !== 33 || done !== 1'b1) begin errors++; $display("[TB] FAIL rd0_done got done %b at E%0d exp 1 at E33", done, e); end
        checks++;
        if (we_out !== x.we || result !== x.res)
            begin errors++; $display("[TB] FAIL rd0_we got we %b res %h exp %b %h", we_out, result, x.we, x.res); end
    endtask

    task automatic test_random();
        int          e;
        int          bc;
        exp_t        x;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        for (int i = 0; i < 10; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = $urandom();
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom();
            if (i == 5) a = 32'hFFFFFF00;
            rd = 5'($urandom_range(1, 31));
            issue(1'b1, f, a, b, rd);
            sb_q.push_back('{res: ref_op(f, a, b), rd: rd, we: 1'b1});
            wait_done(0, e, bc);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rand_%0d scoreboard empty", i);
            end else begin
                x = sb_q.pop_front();
                checks++;
                if (result !== x.res || rd_out !== x.rd || we_out !== x.we || e < 0)
                    begin errors++; $display("[TB] FAIL rand_%0d f %0d a %h b %h got %h rd %0d exp %h rd %0d", i, f, a, b, result, rd_out, x.res, x.rd); end
            end
        end
    endtask

    // Scenario sequence; the summary line is the last thing printed.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_special();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_rd_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
